// File: rtl/door_timer_param_if.sv
// Door timer control/status bundle: controller-side requests and timer status.
// master drives the requests, slave is the timer itself.
interface door_timer_param_if;
  logic       start_timer;
  logic       peso_excesivo;
  logic       bloqueo_activado;
  logic       extend;
  logic       t_expired;
  logic       busy;
  logic [3:0] remaining;
  logic [3:0] ext_count;
  logic [6:0] sseg;

  modport master (
    output start_timer, peso_excesivo, bloqueo_activado, extend,
    input  t_expired, busy, remaining, ext_count, sseg
  );

  modport slave (
    input  start_timer, peso_excesivo, bloqueo_activado, extend,
    output t_expired, busy, remaining, ext_count, sseg
  );
endinterface

// File: rtl/door_timer_param.sv
// Parametrised door-open countdown timer with inhibit hold, bounded reopen
// extensions and a registered 7-segment readout of the seconds remaining.
module door_timer_param #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int TICK_FREQ    = 1,
  parameter int TIMEOUT      = 5,
  parameter int EXTEND_LIMIT = 3,
  parameter int PRE_W        = 27
) (
  input  logic                clk,
  input  logic                restart,
  door_timer_param_if.slave   bus
);

  localparam logic [PRE_W-1:0] DIV_M1   = PRE_W'(CLK_FREQ / TICK_FREQ - 1);
  localparam logic [3:0]       TIMEOUT_V = 4'(TIMEOUT);
  localparam logic [3:0]       EXT_LIM_V = 4'(EXTEND_LIMIT);
  localparam logic [6:0]       SEG_DASH  = 7'b1111110;
  localparam logic [6:0]       SEG_ZERO  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             inhibit;
  logic             ext_ok;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign inhibit = bus.peso_excesivo | bus.bloqueo_activado;
  assign tick    = (state == RUN) && (pre == DIV_M1);
  // A refused extension (limit reached) leaves the tick free to act this cycle.
  assign ext_ok  = bus.extend && (bus.ext_count < EXT_LIM_V);

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state         <= IDLE;
      pre           <= '0;
      bus.remaining <= 4'd0;
      bus.ext_count <= 4'd0;
      bus.t_expired <= 1'b0;
      bus.busy      <= 1'b0;
      bus.sseg      <= SEG_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_timer) begin
            pre           <= '0;
            bus.remaining <= TIMEOUT_V;
            bus.ext_count <= 4'd0;
            bus.busy      <= 1'b1;
            bus.t_expired <= 1'b0;
            if (inhibit) begin
              state    <= HOLD;
              bus.sseg <= SEG_DASH;
            end else begin
              state    <= RUN;
              bus.sseg <= seg7(TIMEOUT_V);
            end
          end
        end

        RUN: begin
          if (!bus.start_timer) begin
            state         <= IDLE;
            pre           <= '0;
            bus.remaining <= 4'd0;
            bus.busy      <= 1'b0;
            bus.t_expired <= 1'b0;
            bus.sseg      <= SEG_ZERO;
          end else if (inhibit) begin
            state    <= HOLD;
            pre      <= '0;
            bus.sseg <= SEG_DASH;
          end else if (ext_ok) begin
            pre           <= '0;
            bus.remaining <= TIMEOUT_V;
            bus.ext_count <= bus.ext_count + 4'd1;
            bus.sseg      <= seg7(TIMEOUT_V);
          end else if (tick) begin
            pre <= '0;
            if (bus.remaining <= 4'd1) begin
              state         <= EXPIRED;
              bus.remaining <= 4'd0;
              bus.t_expired <= 1'b1;
              bus.busy      <= 1'b0;
              bus.sseg      <= SEG_ZERO;
            end else begin
              bus.remaining <= bus.remaining - 4'd1;
              bus.sseg      <= seg7(bus.remaining - 4'd1);
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end

        HOLD: begin
          if (!bus.start_timer) begin
            state         <= IDLE;
            pre           <= '0;
            bus.remaining <= 4'd0;
            bus.busy      <= 1'b0;
            bus.t_expired <= 1'b0;
            bus.sseg      <= SEG_ZERO;
          end else begin
            // Resuming always starts a full prescaler period.
            pre <= '0;
            if (ext_ok) begin
              bus.remaining <= TIMEOUT_V;
              bus.ext_count <= bus.ext_count + 4'd1;
            end
            if (inhibit) begin
              bus.sseg <= SEG_DASH;
            end else begin
              state    <= RUN;
              bus.sseg <= seg7(ext_ok ? TIMEOUT_V : bus.remaining);
            end
          end
        end

        EXPIRED: begin
          if (!bus.start_timer) begin
            state         <= IDLE;
            pre           <= '0;
            bus.remaining <= 4'd0;
            bus.t_expired <= 1'b0;
            bus.busy      <= 1'b0;
            bus.sseg      <= SEG_ZERO;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_door_timer_param.sv
// Bench for door_timer_param: directed scenarios plus randomized stimulus
// against a seconds/phase reference model; a second instance covers TIMEOUT=9, DIV=4.
module tb_door_timer_param;

  localparam int DIV = 10;
  localparam int TO  = 3;
  localparam int EL  = 2;

  logic clk = 1'b0;
  logic restart;
  always #5 clk = ~clk;

  door_timer_param_if bus  ();
  door_timer_param_if bus9 ();

  door_timer_param #(
    .CLK_FREQ(10), .TICK_FREQ(1), .TIMEOUT(TO), .EXTEND_LIMIT(EL), .PRE_W(8)
  ) dut (
    .clk(clk), .restart(restart), .bus(bus.slave)
  );

  door_timer_param #(
    .CLK_FREQ(4), .TICK_FREQ(1), .TIMEOUT(9), .EXTEND_LIMIT(2), .PRE_W(4)
  ) dut9 (
    .clk(clk), .restart(restart), .bus(bus9.slave)
  );

  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: mode 0 idle, 1 counting, 2 held, 3 expired;
  // ph counts clock cycles into the current second.
  int m_mode, m_rem, m_ext, m_ph;

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_ext = 0; m_ph = 0;
  endtask

  task automatic model_step(input bit st, input bit pe, input bit bl, input bit ex);
    bit inh;
    bit acc;
    inh = pe | bl;
    acc = ex && (m_ext < EL);
    case (m_mode)
      0: if (st) begin
        m_rem = TO; m_ext = 0; m_ph = 0;
        m_mode = inh ? 2 : 1;
      end
      1: begin
        if (!st) begin m_mode = 0; m_rem = 0; m_ph = 0; end
        else if (inh) begin m_mode = 2; m_ph = 0; end
        else if (acc) begin m_rem = TO; m_ext++; m_ph = 0; end
        else if (m_ph == DIV - 1) begin
          m_ph = 0;
          if (m_rem == 1) begin m_mode = 3; m_rem = 0; end
          else m_rem--;
        end else m_ph++;
      end
      2: begin
        if (!st) begin m_mode = 0; m_rem = 0; m_ph = 0; end
        else begin
          m_ph = 0;
          if (acc) begin m_rem = TO; m_ext++; end
          if (!inh) m_mode = 1;
        end
      end
      default: if (!st) begin m_mode = 0; m_rem = 0; end
    endcase
  endtask

  task automatic check_model();
    chk("m_t_expired", bus.t_expired, m_mode == 3);
    chk("m_busy", bus.busy, (m_mode == 1) || (m_mode == 2));
    chk("m_remaining", bus.remaining, m_rem);
    chk("m_ext_count", bus.ext_count, m_ext);
    chk("m_sseg", bus.sseg, (m_mode == 2) ? 7'b1111110 : seg_tab[m_rem]);
  endtask

  task automatic cyc(input bit st, input bit pe, input bit bl, input bit ex);
    @(negedge clk);
    bus.start_timer = st; bus.peso_excesivo = pe;
    bus.bloqueo_activado = bl; bus.extend = ex;
    @(posedge clk);
    if (!restart) model_step(st, pe, bl, ex);
    #1;
    check_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_t_expired"}, bus.t_expired, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_remaining"}, bus.remaining, 0);
    chk({tag, "_ext_count"}, bus.ext_count, 0);
    chk({tag, "_sseg"}, bus.sseg, 7'b0000001);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st, pe, bl, ex;
    restart = 1'b1;
    bus.start_timer = 0; bus.peso_excesivo = 0; bus.bloqueo_activado = 0; bus.extend = 0;
    bus9.start_timer = 0; bus9.peso_excesivo = 0; bus9.bloqueo_activado = 0; bus9.extend = 0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    restart = 1'b0;

    // 1: basic countdown
    cyc(1, 0, 0, 0);
    chk("s1_rem_start", bus.remaining, 3);
    for (int k = 1; k <= 30; k++) begin
      cyc(1, 0, 0, 0);
      if (k == 10) chk("s1_rem2", bus.remaining, 2);
      if (k == 20) chk("s1_rem1", bus.remaining, 1);
      if (k == 29) chk("s1_not_yet", bus.t_expired, 0);
      if (k == 30) begin
        chk("s1_expired", bus.t_expired, 1);
        chk("s1_sseg0", bus.sseg, 7'b0000001);
      end
    end
    cyc(0, 0, 0, 0);
    chk("s1_ack", bus.t_expired, 0);

    // 2: inhibits freeze the count, full period after release
    for (int w = 0; w < 2; w++) begin
      cyc(1, 0, 0, 0);
      for (int k = 1; k <= 10; k++) cyc(1, 0, 0, 0);
      chk("s2_rem2", bus.remaining, 2);
      for (int k = 0; k < 25; k++) begin
        cyc(1, w == 0, w == 1, 0);
        chk("s2_dash", bus.sseg, 7'b1111110);
        chk("s2_frozen", bus.remaining, 2);
      end
      cyc(1, 0, 0, 0);
      for (int k = 1; k <= 10; k++) begin
        cyc(1, 0, 0, 0);
        if (k == 9)  chk("s2_rem_still2", bus.remaining, 2);
        if (k == 10) chk("s2_rem1", bus.remaining, 1);
      end
      cyc(0, 0, 0, 0);
    end

    // 3: extension limit
    cyc(1, 0, 0, 0);
    for (int n = 1; n <= 3; n++) begin
      for (int k = 0; k < 20; k++) cyc(1, 0, 0, 0);
      chk("s3_rem1", bus.remaining, 1);
      cyc(1, 0, 0, 1);
      chk("s3_rem", bus.remaining, (n <= 2) ? 3 : 1);
      chk("s3_ext", bus.ext_count, (n <= 2) ? n : 2);
    end
    cyc(0, 0, 0, 0);

    // 4: extend on the tick cycle, then inhibit on the final tick
    cyc(1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("s4_ext_tick_rem", bus.remaining, 3);
    for (int k = 1; k <= 29; k++) cyc(1, 0, 0, 0);
    chk("s4_rem1", bus.remaining, 1);
    cyc(1, 1, 0, 0);
    chk("s4_hold_rem", bus.remaining, 1);
    chk("s4_hold_noexp", bus.t_expired, 0);
    chk("s4_hold_busy", bus.busy, 1);
    cyc(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) cyc(1, 0, 0, 0);
    chk("s4_expired", bus.t_expired, 1);

    // 5: expired ignores extend/inhibits, abort, async restart
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 1, 1);
      chk("s5_exp_hold", bus.t_expired, 1);
      chk("s5_exp_rem", bus.remaining, 0);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("s5_abort_busy", bus.busy, 0);
    chk("s5_abort_rem", bus.remaining, 0);
    chk("s5_abort_exp", bus.t_expired, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 13; k++) cyc(1, 0, 0, (k == 4));
    @(negedge clk);
    #2;
    restart = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    restart = 1'b0;
    cyc(0, 0, 0, 0);
    chk("s5_stay_idle", bus.busy, 0);
    cyc(1, 0, 0, 0);
    chk("s5_restart_run", bus.remaining, 3);

    // randomized traffic against the model
    st = 1; pe = 0; bl = 0;
    for (int k = 0; k < 3000; k++) begin
      if (st) st = ($urandom_range(0, 79) != 0); else st = ($urandom_range(0, 3) == 0);
      if (pe) pe = ($urandom_range(0, 9) != 0);  else pe = ($urandom_range(0, 59) == 0);
      if (bl) bl = ($urandom_range(0, 9) != 0);  else bl = ($urandom_range(0, 59) == 0);
      ex = ($urandom_range(0, 29) == 0);
      cyc(st, pe, bl, ex);
    end

    // 6: TIMEOUT = 9, DIV = 4 instance
    @(negedge clk);
    bus9.start_timer = 1;
    @(posedge clk); #1;
    chk("s6_rem9", bus9.remaining, 9);
    chk("s6_seg9", bus9.sseg, seg_tab[9]);
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      if ((k % 4 == 0) && (k < 36)) chk("s6_seg", bus9.sseg, seg_tab[9 - k / 4]);
      if (k == 35) chk("s6_not_yet", bus9.t_expired, 0);
      if (k == 36) begin
        chk("s6_expired", bus9.t_expired, 1);
        chk("s6_seg0", bus9.sseg, seg_tab[0]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
